// File: rtl/unfold_packer3.sv
// -----------------------------------------------------------------------------
// unfold_packer3
//
// Serial-to-parallel front end for the 3-way unfolded FIR filter. Collects
// one NBIT sample per VIN cycle and packs every three consecutive samples
// into a group x[3k], x[3k+1], x[3k+2]. Each group is presented on three
// registered lane buses with a one-cycle VOUT pulse. FLUSH emits a pending
// partial group with the missing lanes driven to zero.
//
// Timing: the edge that accepts the completing sample (or the flush) loads
// the lane registers. The next rising edge copies the lanes to DOUT* and
// raises VOUT for one cycle.
//
// Ports:
//   CLK      in   1     system clock, rising edge
//   RST      in   1     asynchronous, active-high reset
//   VIN      in   1     serial sample valid
//   DIN      in   NBIT  serial sample (two's complement, passed through)
//   FLUSH    in   1     emit pending partial group, zero-padded
//   DOUT3k   out  NBIT  lane 0, oldest sample x[3k]
//   DOUT3k1  out  NBIT  lane 1, x[3k+1]
//   DOUT3k2  out  NBIT  lane 2, newest sample x[3k+2]
//   VOUT     out  1     group valid, one-cycle pulse
//   PHASE    out  2     samples held in the partial group (0..2)
//   GRP_CNT  out  CNTW  groups emitted since reset
//
// Configuration macro: UNFOLD_PACKER_GRPCNT_EN
//   defined   : GRP_CNT counts VOUT pulses, wrapping modulo 2^CNTW
//   undefined : no counter logic, GRP_CNT tied to zero
// -----------------------------------------------------------------------------
module unfold_packer3 #(
    parameter int NBIT = 9,
    parameter int CNTW = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            VIN,
    input  logic [NBIT-1:0] DIN,
    input  logic            FLUSH,
    output logic [NBIT-1:0] DOUT3k,
    output logic [NBIT-1:0] DOUT3k1,
    output logic [NBIT-1:0] DOUT3k2,
    output logic            VOUT,
    output logic [1:0]      PHASE,
    output logic [CNTW-1:0] GRP_CNT
);

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } phase_e;

    phase_e          state_q, state_d;
    logic [NBIT-1:0] lane0_q, lane0_d;
    logic [NBIT-1:0] lane1_q, lane1_d;
    logic [NBIT-1:0] lane2_q, lane2_d;
    logic            emit_q,  emit_d;
    logic [NBIT-1:0] dout0_q, dout0_d;
    logic [NBIT-1:0] dout1_q, dout1_d;
    logic [NBIT-1:0] dout2_q, dout2_d;
    logic            vout_q,  vout_d;

    // Next-state and output logic.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        state_d = state_q;
        lane0_d = lane0_q;
        lane1_d = lane1_q;
        lane2_d = lane2_q;
        emit_d  = 1'b0;
        dout0_d = dout0_q;
        dout1_d = dout1_q;
        dout2_d = dout2_q;
        vout_d  = emit_q;

        // A group marked last cycle moves to the outputs now, and its lanes
        // are cleared so a later zero-padded flush can never pick up stale
        // samples. The state is S0 here, so a new sample can only land in
        // lane 0 below, overriding the clear.
        if (emit_q) begin
            dout0_d = lane0_q;
            dout1_d = lane1_q;
            dout2_d = lane2_q;
            lane0_d = '0;
            lane1_d = '0;
            lane2_d = '0;
        end

        if (VIN) begin
            case (state_q)
                S0:      lane0_d = DIN;
                S1:      lane1_d = DIN;
                S2:      lane2_d = DIN;
                default: ;
            endcase
        end

        // The sample is accepted before FLUSH is considered; a flush only
        // emits when the partial group (including this sample) is non-empty.
        emit_d = (VIN && (state_q == S2)) ||
                 (FLUSH && (VIN || (state_q != S0)));

        if (emit_d) begin
            state_d = S0;
        end else if (VIN) begin
            case (state_q)
                S0:      state_d = S1;
                S1:      state_d = S2;
                default: state_d = S0;
            endcase
        end
    end

    // State and data registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            // NOTE: the lane registers are reset too, not just the control
            // state: unfilled lanes become the zero padding of a flushed group.
            state_q <= S0;
            lane0_q <= '0;
            lane1_q <= '0;
            lane2_q <= '0;
            emit_q  <= 1'b0;
            dout0_q <= '0;
            dout1_q <= '0;
            dout2_q <= '0;
            vout_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of every other flop.
            state_q <= state_d;
            lane0_q <= lane0_d;
            lane1_q <= lane1_d;
            lane2_q <= lane2_d;
            emit_q  <= emit_d;
            dout0_q <= dout0_d;
            dout1_q <= dout1_d;
            dout2_q <= dout2_d;
            vout_q  <= vout_d;
        end
    end

    assign DOUT3k  = dout0_q;
    assign DOUT3k1 = dout1_q;
    assign DOUT3k2 = dout2_q;
    assign VOUT    = vout_q;
    assign PHASE   = state_q;

`ifdef UNFOLD_PACKER_GRPCNT_EN
    logic [CNTW-1:0] grp_cnt_q, grp_cnt_d;

    // Counts in step with the VOUT register; wraps naturally at 2^CNTW.
    always_comb begin
        grp_cnt_d = grp_cnt_q;
        if (emit_q) begin
            grp_cnt_d = grp_cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            grp_cnt_q <= '0;
        end else begin
            grp_cnt_q <= grp_cnt_d;
        end
    end

    assign GRP_CNT = grp_cnt_q;
`else
    assign GRP_CNT = '0;
`endif

endmodule
